mult_iter_radix: RTL and testbench

- Parametrised iterative multiplier: A (A_W bits) * B (B_W bits) -> full A_W+B_W product.
- Retires DIGIT_W bits of B per cycle (radix-2^DIGIT_W shift-add) instead of one, with optional early exit when the remaining B bits are zero.
- Uses valid/ready handshakes on input and output, plus a synchronous abort.
- Drop-in successor for the Poly1305 130x128 limb multiply path in the AES-GCM/Poly1305 datapath, and reusable for other limb sizes.

---
 rtl/mult_iter_radix_pkg.sv | 25 ++
 rtl/mult_digit_pp.sv | 20 ++
 rtl/mult_iter_radix.sv | 135 +++++++++++++
 tb/tb_mult_iter_radix.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_iter_radix_pkg.sv
// Shared constants for the radix-2^DIGIT_W iterative multiplier: FSM encodings
// and the width helpers used to size the iteration counter.
package mult_iter_radix_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

    function automatic int calc_n_iter(input int b_w, input int digit_w);
        return (b_w + digit_w - 1) / digit_w;
    endfunction

    // The counter must be able to hold N_ITER itself, as reported by iter_used.
    function automatic int calc_cnt_w(input int n_iter);
        return clog2(n_iter + 1);
    endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// Partial product of the shifted multiplicand and one DIGIT_W-bit digit of B,
// truncated to the full product width.
module mult_digit_pp #(
    parameter int A_W     = 130,
    parameter int B_W     = 128,
    parameter int DIGIT_W = 4
) (
    input  logic [A_W+B_W-1:0] a_sh_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [A_W+B_W-1:0] pp_o
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0] digit_ext;

    assign digit_ext = P_W'(digit_i);
    assign pp_o      = a_sh_i * digit_ext;

endmodule

// File: rtl/mult_iter_radix.sv
// Iterative unsigned multiplier retiring DIGIT_W bits of B per cycle, with
// valid/ready handshakes, synchronous abort and optional early exit.
module mult_iter_radix
    import mult_iter_radix_pkg::*;
#(
    parameter int A_W        = 130,
    parameter int B_W        = 128,
    parameter int DIGIT_W    = 4,
    parameter int EARLY_EXIT = 1,
    localparam int N_ITER    = calc_n_iter(B_W, DIGIT_W),
    localparam int CNT_W     = calc_cnt_w(N_ITER)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       a_in,
    input  logic [B_W-1:0]       b_in,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   product_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     iter_used
);

    localparam int P_W  = A_W + B_W;
    localparam int BR_W = N_ITER * DIGIT_W;

    logic [1:0]       state_q, state_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic [P_W-1:0]   a_sh_q, a_sh_d;
    logic [BR_W-1:0]  b_rem_q, b_rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P_W-1:0]   product_q, product_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             out_valid_q, out_valid_d;

    logic [P_W-1:0]   pp;
    logic [P_W-1:0]   sum;
    logic [BR_W-1:0]  b_next;
    logic             finish;

    mult_digit_pp #(
        .A_W     (A_W),
        .B_W     (B_W),
        .DIGIT_W (DIGIT_W)
    ) u_pp (
        .a_sh_i  (a_sh_q),
        .digit_i (b_rem_q[DIGIT_W-1:0]),
        .pp_o    (pp)
    );

    assign sum    = acc_q + pp;
    assign b_next = b_rem_q >> DIGIT_W;
    // The digit being consumed now is already folded into sum, so finishing here loses nothing.
    assign finish = (cnt_q == CNT_W'(N_ITER - 1)) || ((EARLY_EXIT != 0) && (b_next == '0));

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        a_sh_d      = a_sh_q;
        b_rem_d     = b_rem_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        iter_d      = iter_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && !abort) begin
                    acc_d   = '0;
                    a_sh_d  = P_W'(a_in);
                    b_rem_d = BR_W'(b_in);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = sum;
                    a_sh_d  = a_sh_q << DIGIT_W;
                    b_rem_d = b_next;
                    cnt_d   = cnt_q + 1'b1;
                    if (finish) begin
                        product_d   = sum;
                        iter_d      = cnt_q + 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (abort || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            a_sh_q      <= '0;
            b_rem_q     <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            a_sh_q      <= a_sh_d;
            b_rem_q     <= b_rem_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            iter_q      <= iter_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_RUN);
    assign out_valid   = out_valid_q;
    assign product_out = product_q;
    assign iter_used   = iter_q;

endmodule

// File: tb/tb_mult_iter_radix.sv
// Self-checking bench: five multiplier configurations sharing one clock and reset,
// scoreboarded against a wide-multiply reference model.
module tb_mult_iter_radix;
    import mult_iter_radix_pkg::*;

    localparam int A_W   = 130;
    localparam int B_W   = 128;
    localparam int P_W   = A_W + B_W;
    localparam int N_DUT = 5;

    typedef struct {
        logic [P_W-1:0] prod;
        int             iter;
    } exp_t;

    function automatic int dut_digit(input int g);
        case (g)
            0:       return 4;
            1:       return 3;
            2:       return 1;
            3:       return 128;
            default: return 4;
        endcase
    endfunction

    function automatic int dut_ee(input int g);
        return (g == 1 || g == 3 || g == 4) ? 0 : 1;
    endfunction

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [A_W-1:0]       a_in;
    logic [B_W-1:0]       b_in;
    logic [N_DUT-1:0]     in_valid;
    logic [N_DUT-1:0]     abort_v;
    logic [N_DUT-1:0]     out_ready;
    logic [N_DUT-1:0]     in_ready;
    logic [N_DUT-1:0]     out_valid;
    logic [N_DUT-1:0]     busy;
    logic [P_W-1:0]       product [N_DUT];
    logic [7:0]           iter_used [N_DUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int D  = dut_digit(g);
        localparam int CW = calc_cnt_w(calc_n_iter(B_W, D));
        logic           rdy, vld, bsy;
        logic [P_W-1:0] prod;
        logic [CW-1:0]  iu;

        mult_iter_radix #(
            .A_W        (A_W),
            .B_W        (B_W),
            .DIGIT_W    (D),
            .EARLY_EXIT (dut_ee(g))
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .in_valid    (in_valid[g]),
            .in_ready    (rdy),
            .a_in        (a_in),
            .b_in        (b_in),
            .abort       (abort_v[g]),
            .out_valid   (vld),
            .out_ready   (out_ready[g]),
            .product_out (prod),
            .busy        (bsy),
            .iter_used   (iu)
        );

        assign in_ready[g]  = rdy;
        assign out_valid[g] = vld;
        assign busy[g]      = bsy;
        assign product[g]   = prod;
        assign iter_used[g] = 8'(iu);
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [P_W-1:0] obs, input logic [P_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_iter(input int g, input logic [B_W-1:0] b);
        int d;
        int msb;
        d   = dut_digit(g);
        msb = -1;
        if (dut_ee(g) == 0) return (B_W + d - 1) / d;
        for (int i = 0; i < B_W; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + d) / d;
    endfunction

    task automatic wait_out(input int g, output int cyc);
        cyc = 0;
        while (!out_valid[g] && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Returns at the falling edge right after the accept edge.
    task automatic start_op(input int g, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        exp_t e;
        @(negedge clk);
        check($sformatf("in_ready_idle[%0d]", g), P_W'(in_ready[g]), P_W'(1));
        a_in        = a;
        b_in        = b;
        in_valid[g] = 1'b1;
        e.prod      = P_W'(a) * P_W'(b);
        e.iter      = exp_iter(g, b);
        sb.push_back(e);
        @(negedge clk);
        in_valid[g] = 1'b0;
        a_in        = ~a;
        b_in        = ~b;
    endtask

    task automatic finish_op(input int g, input int hold_cycles);
        int   cyc;
        exp_t e;
        wait_out(g, cyc);
        e = sb.pop_front();
        check($sformatf("latency[%0d]", g), P_W'(cyc), P_W'(e.iter));
        for (int k = 0; k < hold_cycles; k++) begin
            in_valid[g] = k[0];
            @(negedge clk);
            check($sformatf("hold_valid[%0d]", g), P_W'(out_valid[g]), P_W'(1));
            check($sformatf("hold_product[%0d]", g), product[g], e.prod);
            check($sformatf("hold_in_ready[%0d]", g), P_W'(in_ready[g]), P_W'(0));
        end
        in_valid[g] = 1'b0;
        check($sformatf("product[%0d]", g), product[g], e.prod);
        check($sformatf("iter_used[%0d]", g), P_W'(iter_used[g]), P_W'(e.iter));
        out_ready[g] = 1'b1;
        @(negedge clk);
        out_ready[g] = 1'b0;
        check($sformatf("consumed_valid[%0d]", g), P_W'(out_valid[g]), P_W'(0));
        check($sformatf("consumed_in_ready[%0d]", g), P_W'(in_ready[g]), P_W'(1));
        check($sformatf("consumed_busy[%0d]", g), P_W'(busy[g]), P_W'(0));
    endtask

    task automatic run_op(input int g, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        start_op(g, a, b);
        finish_op(g, 0);
    endtask

    function automatic logic [A_W-1:0] rand_a();
        return {2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [B_W-1:0] rand_b();
        logic [B_W-1:0] b;
        b = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        return b >> $urandom_range(0, B_W - 1);
    endfunction

    initial begin
        int             cyc;
        int             n_rand [N_DUT];
        logic           rose;
        logic [P_W-1:0] kept_prod;
        exp_t           e;

        n_rand    = '{150, 80, 30, 150, 40};
        reset_n   = 1'b0;
        in_valid  = '0;
        abort_v   = '0;
        out_ready = '0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < N_DUT; g++) begin
            check($sformatf("rst_in_ready[%0d]", g), P_W'(in_ready[g]), P_W'(1));
            check($sformatf("rst_out_valid[%0d]", g), P_W'(out_valid[g]), P_W'(0));
            check($sformatf("rst_busy[%0d]", g), P_W'(busy[g]), P_W'(0));
            check($sformatf("rst_product[%0d]", g), product[g], '0);
            check($sformatf("rst_iter[%0d]", g), P_W'(iter_used[g]), '0);
        end
        reset_n = 1'b1;

        // Directed corner operands
        run_op(0, '1, '1);
        run_op(0, 130'd5, 128'h13);
        run_op(0, 130'd5, 128'h0);
        run_op(4, 130'd5, 128'h13);
        run_op(3, '1, '1);
        run_op(2, 130'd9, 128'd1);
        run_op(1, rand_a(), {1'b1, 127'($urandom)});
        run_op(1, '1, '1);

        for (int g = 0; g < N_DUT; g++)
            for (int i = 0; i < n_rand[g]; i++)
                run_op(g, rand_a(), rand_b());

        // Back-pressure: result held while in_valid pulses are ignored
        start_op(0, 130'd7, 128'd9);
        finish_op(0, 10);

        // Abort in IDLE blocks acceptance
        @(negedge clk);
        in_valid[0] = 1'b1;
        abort_v[0]  = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        abort_v[0]  = 1'b0;
        check("abort_idle_busy", P_W'(busy[0]), P_W'(0));
        check("abort_idle_in_ready", P_W'(in_ready[0]), P_W'(1));

        // Abort mid-RUN on the fixed-latency instance
        run_op(1, 130'd11, 128'd13);
        start_op(1, rand_a(), {1'b1, 127'($urandom)});
        void'(sb.pop_back());
        repeat (4) @(negedge clk);
        abort_v[1] = 1'b1;
        @(negedge clk);
        abort_v[1] = 1'b0;
        check("abort_run_busy", P_W'(busy[1]), P_W'(0));
        check("abort_run_in_ready", P_W'(in_ready[1]), P_W'(1));
        check("abort_run_product_kept", product[1], P_W'(143));
        check("abort_run_iter_kept", P_W'(iter_used[1]), P_W'(43));
        rose = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid[1]) rose = 1'b1;
        end
        check("abort_run_no_valid", P_W'(rose), P_W'(0));
        run_op(1, 130'd3, 128'd7);
        check("after_abort_product", product[1], P_W'(21));

        // Abort together with out_ready in HOLD
        start_op(0, 130'd6, 128'd7);
        wait_out(0, cyc);
        e = sb.pop_front();
        check("abort_hold_latency", P_W'(cyc), P_W'(e.iter));
        abort_v[0]   = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        abort_v[0]   = 1'b0;
        out_ready[0] = 1'b0;
        check("abort_hold_valid", P_W'(out_valid[0]), P_W'(0));
        check("abort_hold_in_ready", P_W'(in_ready[0]), P_W'(1));
        check("abort_hold_product_kept", product[0], P_W'(42));

        // Synchronous reset mid-RUN
        kept_prod = product[0];
        check("pre_reset_product_nonzero", P_W'(kept_prod == '0), P_W'(0));
        start_op(0, rand_a(), {1'b1, 127'($urandom)});
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_in_ready", P_W'(in_ready[0]), P_W'(1));
        check("mid_rst_out_valid", P_W'(out_valid[0]), P_W'(0));
        check("mid_rst_busy", P_W'(busy[0]), P_W'(0));
        check("mid_rst_product", product[0], '0);
        check("mid_rst_iter", P_W'(iter_used[0]), '0);

        // A reset_n glitch between edges must not disturb a running operation
        start_op(0, 130'd1234567, {1'b1, 127'd99});
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        finish_op(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
